// File: rtl/puf_hash_pkg.sv
// Shared types and constants for the PUF-response hashing controller.
// Optional salt support is selected by the PUF_HASH_NONCE_EN macro.
package puf_hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_START,
    ST_ARM,
    ST_BUSY,
    ST_HOLD
  } state_e;

  localparam logic        MODE_SHA_256 = 1'b1;
  localparam int unsigned RESP_W       = 256;
  localparam int unsigned NONCE_W      = 64;
  localparam int unsigned DIG_W        = 256;
  localparam int unsigned BLOCK_W      = 512;
  localparam int unsigned LEN_W        = 64;

`ifdef PUF_HASH_NONCE_EN
  localparam int unsigned MSG_LEN_BITS = 320;
  localparam int unsigned PAD_BIT_POS  = 191;

  typedef struct packed {
    logic [RESP_W-1:0]  resp;
    logic [NONCE_W-1:0] nonce;
  } puf_msg_t;
`else
  localparam int unsigned MSG_LEN_BITS = 256;
  localparam int unsigned PAD_BIT_POS  = 255;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
  } puf_msg_t;
`endif

endpackage

// File: rtl/puf_hash_ctrl_if.sv
// Bundle of the response, core and digest handshakes around puf_hash_ctrl.
// The nonce signal exists only when PUF_HASH_NONCE_EN is defined.
interface puf_hash_ctrl_if;
  import puf_hash_pkg::*;

  logic               resp_valid;
  logic               resp_ready;
  logic [RESP_W-1:0]  resp_data;
`ifdef PUF_HASH_NONCE_EN
  logic [NONCE_W-1:0] nonce;
`endif
  logic               core_init;
  logic               core_next;
  logic               core_mode;
  logic [BLOCK_W-1:0] core_block;
  logic               core_ready;
  logic [DIG_W-1:0]   core_digest;
  logic               core_digest_valid;
  logic               dig_valid;
  logic               dig_ready;
  logic [DIG_W-1:0]   dig_data;
  logic               err;

  // Controller side
  modport master (
`ifdef PUF_HASH_NONCE_EN
    input  nonce,
`endif
    input  resp_valid, resp_data, core_ready, core_digest, core_digest_valid, dig_ready,
    output resp_ready, core_init, core_next, core_mode, core_block, dig_valid, dig_data, err
  );

  // Environment side (PUF register, sha256_core, digest consumer)
  modport slave (
`ifdef PUF_HASH_NONCE_EN
    output nonce,
`endif
    output resp_valid, resp_data, core_ready, core_digest, core_digest_valid, dig_ready,
    input  resp_ready, core_init, core_next, core_mode, core_block, dig_valid, dig_data, err
  );

endinterface

// File: rtl/puf_hash_pad.sv
// Combinational SHA-256 padder: message (response, optionally nonce) to one 512-bit block.
// Layout depends on PUF_HASH_NONCE_EN through the package constants.
module puf_hash_pad
  import puf_hash_pkg::*;
(
  input  puf_msg_t           msg,
  output logic [BLOCK_W-1:0] block_c
);

  always_comb begin
    block_c = '0;
    block_c[BLOCK_W-1 -: RESP_W] = msg.resp;
`ifdef PUF_HASH_NONCE_EN
    block_c[BLOCK_W-RESP_W-1 -: NONCE_W] = msg.nonce;
`endif
    block_c[PAD_BIT_POS] = 1'b1;
    block_c[LEN_W-1:0]   = LEN_W'(MSG_LEN_BITS);
  end

endmodule

// File: rtl/puf_hash_ctrl.sv
// Sequences one single-block sha256_core job per PUF response and holds the digest
// until taken downstream; aborts with an err pulse if the core stalls. Macro: PUF_HASH_NONCE_EN.
module puf_hash_ctrl
  import puf_hash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 127
) (
  input  logic             clk,
  input  logic             reset_n,
  puf_hash_ctrl_if.master  bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               dig_valid_q, dig_valid_d;
  logic               resp_ready_q, resp_ready_d;
  logic               core_init_q, core_init_d;
  logic               err_q, err_d;

  puf_msg_t           msg_c;
  logic [BLOCK_W-1:0] pad_block_c;

  always_comb begin
    msg_c.resp = bus.resp_data;
`ifdef PUF_HASH_NONCE_EN
    msg_c.nonce = bus.nonce;
`endif
  end

  puf_hash_pad u_pad (
    .msg     (msg_c),
    .block_c (pad_block_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      block_q      <= '0;
      dig_q        <= '0;
      dig_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
      core_init_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      block_q      <= block_d;
      dig_q        <= dig_d;
      dig_valid_q  <= dig_valid_d;
      resp_ready_q <= resp_ready_d;
      core_init_q  <= core_init_d;
      err_q        <= err_d;
    end
  end

  // Handshake outputs are registered from the next state so each is a clean flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    dig_d   = dig_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.resp_valid) begin
          block_d = pad_block_c;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (bus.core_ready) state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (bus.core_digest_valid && bus.core_ready) begin
          dig_d   = bus.core_digest;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.dig_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    resp_ready_d = (state_d == ST_IDLE);
    core_init_d  = (state_d == ST_START);
    dig_valid_d  = (state_d == ST_HOLD);
  end

  assign bus.resp_ready = resp_ready_q;
  assign bus.core_init  = core_init_q;
  assign bus.core_next  = 1'b0;
  assign bus.core_mode  = MODE_SHA_256;
  assign bus.core_block = block_q;
  assign bus.dig_valid  = dig_valid_q;
  assign bus.dig_data   = dig_q;
  assign bus.err        = err_q;

endmodule
